// File: rtl/vai_tx_skid_pkg.sv
// Shared constants for the per-sub-AFU Tx skid buffer: default channel widths,
// overflow_err bit positions and the almost-full threshold helper.
package vai_tx_skid_pkg;

    localparam int VAI_C0_W = 74;
    localparam int VAI_C1_W = 592;
    localparam int VAI_C2_W = 73;

    localparam int OVF_C0_BIT = 0;
    localparam int OVF_C1_BIT = 1;

    function automatic int almfull_thresh(input int depth, input int slack);
        return depth - slack;
    endfunction

endpackage

// File: rtl/vai_skid_fifo.sv
// Single-channel skid FIFO: absorbs post-almost-full requests, regenerates
// almost-full from occupancy and flags drops when full with no pop.
module vai_skid_fifo
    import vai_tx_skid_pkg::*;
#(
    parameter int WIDTH = 74,
    parameter int DEPTH = 16,
    parameter int SLACK = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_dn_almfull,
    output logic             o_almfull,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH   = CW'(almfull_thresh(DEPTH, SLACK));
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic             r_almfull;
    logic             r_overflow;
    logic [WIDTH-1:0] r_data;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [CW-1:0]    w_count_next;

    // Push/pop decisions; a pop in the same cycle frees room for a push when full.
    always_comb begin
        w_full = (r_count == FULL_CNT);
        w_pop  = (r_count != {CW{1'b0}}) && !i_dn_almfull;
        w_push = i_valid && (!w_full || w_pop);
        w_drop = i_valid && w_full && !w_pop;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_ONE;
        end else begin
            w_count_next = r_count;
        end
    end

    // Pointers, occupancy, output valid, almost-full and sticky overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wptr     <= {AW{1'b0}};
            r_rptr     <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_valid    <= 1'b0;
            r_almfull  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            r_count    <= w_count_next;
            r_valid    <= w_pop;
            r_almfull  <= (w_count_next >= THRESH);
            r_overflow <= r_overflow | w_drop;
        end
    end

    // Storage and head capture; data needs no reset since valid qualifies it.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
        if (w_pop)  r_data <= r_mem[r_rptr];
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_almfull  = r_almfull;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/vai_tx_skid.sv
// Per-sub-AFU CCI-P Tx request buffer: c0/c1 skid FIFOs plus a registered
// c2 MMIO response stage.
module vai_tx_skid
    import vai_tx_skid_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SLACK = 8,
    parameter int C0_W  = VAI_C0_W,
    parameter int C1_W  = VAI_C1_W,
    parameter int C2_W  = VAI_C2_W
) (
    input  logic            pClk,
    input  logic            SoftReset,
    input  logic            afu_c0_valid,
    input  logic [C0_W-1:0] afu_c0_req,
    input  logic            afu_c1_valid,
    input  logic [C1_W-1:0] afu_c1_req,
    input  logic            afu_c2_valid,
    input  logic [C2_W-1:0] afu_c2_rsp,
    output logic            afu_c0_almfull,
    output logic            afu_c1_almfull,
    input  logic            dn_c0_almfull,
    input  logic            dn_c1_almfull,
    output logic            dn_c0_valid,
    output logic [C0_W-1:0] dn_c0_req,
    output logic            dn_c1_valid,
    output logic [C1_W-1:0] dn_c1_req,
    output logic            dn_c2_valid,
    output logic [C2_W-1:0] dn_c2_rsp,
    output logic [1:0]      overflow_err
);

    logic            w_ovf_c0;
    logic            w_ovf_c1;
    logic            r_c2_valid;
    logic [C2_W-1:0] r_c2_rsp;

    vai_skid_fifo #(.WIDTH(C0_W), .DEPTH(DEPTH), .SLACK(SLACK)) u_c0_fifo (
        .clk          (pClk),
        .srst         (SoftReset),
        .i_valid      (afu_c0_valid),
        .i_data       (afu_c0_req),
        .i_dn_almfull (dn_c0_almfull),
        .o_almfull    (afu_c0_almfull),
        .o_valid      (dn_c0_valid),
        .o_data       (dn_c0_req),
        .o_overflow   (w_ovf_c0)
    );

    vai_skid_fifo #(.WIDTH(C1_W), .DEPTH(DEPTH), .SLACK(SLACK)) u_c1_fifo (
        .clk          (pClk),
        .srst         (SoftReset),
        .i_valid      (afu_c1_valid),
        .i_data       (afu_c1_req),
        .i_dn_almfull (dn_c1_almfull),
        .o_almfull    (afu_c1_almfull),
        .o_valid      (dn_c1_valid),
        .o_data       (dn_c1_req),
        .o_overflow   (w_ovf_c1)
    );

    // c2 valid: one register stage, no backpressure.
    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            r_c2_valid <= 1'b0;
        end else begin
            r_c2_valid <= afu_c2_valid;
        end
    end

    // c2 payload register.
    always_ff @(posedge pClk) begin
        r_c2_rsp <= afu_c2_rsp;
    end

    assign dn_c2_valid = r_c2_valid;
    assign dn_c2_rsp   = r_c2_rsp;

    assign overflow_err[OVF_C0_BIT] = w_ovf_c0;
    assign overflow_err[OVF_C1_BIT] = w_ovf_c1;

endmodule
